ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit of the npc core; sits directly upstream of the decode/control stage.
- Owns the architectural PC and issues one fetch at a time to instruction memory over a valid/ready request channel plus a response-valid channel.
- Holds the fetched instruction stable and presents pre-split decode fields (opcode, funct3, funct7 bit, register indices) until execute commits and returns the next PC.
- Tracks retired-instruction count, halt, and fetch-timeout error.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- TIMEOUT, 1024, max cycles in WAIT before error; range 2..65535.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address (= pc)
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  response data valid
- imem_rsp_data  input  32  fetched instruction word
- commit  input  1  execute finished current instruction
- next_pc  input  32  PC of next instruction, sampled on commit
- halt  input  1  current instruction is a halt; sampled on commit
- inst_valid  output  1  inst and fields valid for decode
- inst  output  32  held instruction
- pc  output  32  PC of held instruction
- opcode  output  7  inst[6:0]
- funct3  output  3  inst[14:12]
- funct7  output  1  inst[30]
- rs1  output  5  inst[19:15]
- rs2  output  5  inst[24:20]
- rd  output  5  inst[11:7]
- instret  output  64  retired-instruction counter
- halted  output  1  sticky, core stopped
- fetch_err  output  1  sticky, timeout occurred
- misalign  output  1  sticky, next_pc[1:0] != 0 seen on commit

Behaviour:
- Reset:
  - One clock, synchronous, active-high: rst sampled high on a clk rising edge resets the block at that edge.
  - Reset values: state=REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), instret=0, halted=0, fetch_err=0, misalign=0, timeout counter=0.
  - Reset overrides every other input, including mid-WAIT and mid-EXEC. A response arriving after reset, for a pre-reset request, is ignored unless the unit has re-entered WAIT.
- Decode fields are pure slices of the inst register, so they are valid whenever inst_valid=1.
- States: REQ, WAIT, EXEC, HALT, ERR.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_ready=1 -> WAIT and clear timeout counter; else stay in REQ.
  - imem_rsp_valid is ignored.
- WAIT:
  - imem_req_valid=0; timeout counter increments each cycle.
  - imem_rsp_valid=1 -> latch inst=imem_rsp_data, go to EXEC.
  - Otherwise, when counter reaches TIMEOUT-1 -> ERR and set fetch_err.
  - If the response arrives on the timeout cycle, the response wins.
  - Minimum fetch latency: request accept at cycle N, earliest inst_valid at N+2.
- EXEC:
  - inst_valid=1; inst and pc held stable.
  - commit=1 causes all of the following at the same edge:
    - pc <= {next_pc[31:2],2'b00}
    - misalign |= (next_pc[1:0] != 0)
    - instret <= instret+1 (wraps at 2^64-1 -> 0)
  - Then commit with halt=1 -> HALT and set halted; otherwise -> REQ.
  - commit=0 -> stay in EXEC.
- HALT and ERR:
  - Terminal until rst.
  - imem_req_valid=0, inst_valid=0; pc, inst and instret frozen.
  - commit, halt and imem_rsp_valid are ignored.
- commit outside EXEC is ignored: no PC or instret change.
- imem_rsp_valid outside WAIT is ignored.
- Registered outputs change only on clk rising edges.
- Combinational outputs: imem_req_valid and inst_valid are decoded from state only. There are no combinational paths from inputs to outputs.

Test Plan:
- Basic fetch: reset; ready=1 at cycle 1; rsp_valid=1 with 32'h00500093 at cycle 3 -> at cycle 4 inst_valid=1, pc=32'h8000_0000, opcode=7'h13, rd=1, rs1=0; commit with next_pc=32'h8000_0004 -> next cycle req_valid=1, addr=32'h8000_0004, instret=1.
- Backpressure/latency: ready=0 for 5 cycles -> req_valid stays 1 with a stable address; then ready=1, and rsp_valid delayed 10 cycles -> inst_valid rises exactly one cycle after rsp_valid; no second request is issued.
- Branch redirect and misalign: commit with next_pc=32'h8000_0102 -> pc=32'h8000_0100, misalign=1 (sticky across later commits).
- Halt: commit with halt=1 (inst=32'h00100073) -> halted=1, req_valid stays 0 for 20 cycles, instret frozen; further commit pulses change nothing.
- Timeout: TIMEOUT=8; accept request, never assert rsp_valid -> fetch_err=1 exactly 8 cycles after entering WAIT; a response with rsp_valid on the 8th WAIT cycle instead gives EXEC and fetch_err=0.
- Reset mid-operation: assert rst during WAIT and during EXEC -> next cycle state=REQ, pc=RESET_PC, instret=0, all sticky flags cleared, stale rsp_valid in REQ ignored.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with held decode fields, retire count and sticky status flags
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        commit,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [63:0] instret,
  output logic        halted,
  output logic        fetch_err,
  output logic        misalign
);
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_EXEC, S_HALT, S_ERR} state_e;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic [15:0] cnt_q, cnt_d;
  logic        halted_q, halted_d, fetch_err_q, fetch_err_d, misalign_q, misalign_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0000_0013;
      instret_q   <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instret_q   <= instret_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
      misalign_q  <= misalign_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instret_d   = instret_q;
    cnt_d       = cnt_q;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;
    misalign_d  = misalign_q;
    case (state_q)
      S_REQ: if (imem_req_ready) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // a response on the final timeout cycle still wins over the error
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_EXEC;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_ERR;
          fetch_err_d = 1'b1;
        end
      end
      S_EXEC: if (commit) begin
        pc_d       = {next_pc[31:2], 2'b00};
        misalign_d = misalign_q | (|next_pc[1:0]);
        instret_d  = instret_q + 64'd1;
        halted_d   = halted_q | halt;
        state_d    = halt ? S_HALT : S_REQ;
      end
      default: ;
    endcase
  end
  assign imem_req_valid = state_q == S_REQ;
  assign inst_valid     = state_q == S_EXEC;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign opcode         = inst_q[6:0];
  assign funct3         = inst_q[14:12];
  assign funct7         = inst_q[30];
  assign rs1            = inst_q[19:15];
  assign rs2            = inst_q[24:20];
  assign rd             = inst_q[11:7];
  assign instret        = instret_q;
  assign halted         = halted_q;
  assign fetch_err      = fetch_err_q;
  assign misalign       = misalign_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: per-cycle vector table plus hand sequences for backpressure, latency and halt
module tb_ifu_fetch;
  localparam logic [31:0] P0  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid, commit, halt;
  logic        inst_valid, funct7, halted, fetch_err, misalign;
  logic [31:0] imem_req_addr, imem_rsp_data, next_pc, inst, pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] instret;
  int total = 0, bad = 0;
  typedef struct {
    logic r, rdy, rv;
    logic [31:0] d;
    logic cm;
    logic [31:0] npc;
    logic hl;
    logic e_req, e_iv;
    logic [31:0] e_pc, e_inst;
    logic [63:0] e_ir;
    logic e_h, e_fe, e_mis;
  } vec_t;
  vec_t vq[$];
  ifu_fetch #(.RESET_PC(P0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .commit(commit), .next_pc(next_pc), .halt(halt),
    .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .instret(instret), .halted(halted), .fetch_err(fetch_err), .misalign(misalign)
  );
  always #5 clk = ~clk;
  function automatic void add(input logic r, rdy, rv, input logic [31:0] d, input logic cm,
                              input logic [31:0] npc, input logic hl, input logic e_req, e_iv,
                              input logic [31:0] e_pc, e_inst, input logic [63:0] e_ir,
                              input logic e_h, e_fe, e_mis);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rv = rv; v.d = d; v.cm = cm; v.npc = npc; v.hl = hl;
    v.e_req = e_req; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst; v.e_ir = e_ir;
    v.e_h = e_h; v.e_fe = e_fe; v.e_mis = e_mis;
    vq.push_back(v);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, rdy, rv, input logic [31:0] d, input logic cm,
                      input logic [31:0] npc, input logic hl);
    rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
    commit = cm; next_pc = npc; halt = hl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    add(1,0,0,0,0,0,0,                      1,0,P0,NOP,0,0,0,0);
    add(0,1,0,0,0,0,0,                      0,0,P0,NOP,0,0,0,0);
    add(0,0,0,0,0,0,0,                      0,0,P0,NOP,0,0,0,0);
    add(0,0,1,32'h00500093,0,0,0,           0,1,P0,32'h00500093,0,0,0,0);
    add(0,0,0,0,1,32'h80000004,0,           1,0,32'h80000004,32'h00500093,1,0,0,0);
    add(0,0,1,32'hdeadbeef,0,0,0,           1,0,32'h80000004,32'h00500093,1,0,0,0);
    add(0,1,0,0,0,0,0,                      0,0,32'h80000004,32'h00500093,1,0,0,0);
    add(0,0,1,32'h00208133,0,0,0,           0,1,32'h80000004,32'h00208133,1,0,0,0);
    add(0,0,0,0,0,0,0,                      0,1,32'h80000004,32'h00208133,1,0,0,0);
    add(0,0,0,0,1,32'h80000102,0,           1,0,32'h80000100,32'h00208133,2,0,0,1);
    add(0,0,0,0,1,32'h00000000,0,           1,0,32'h80000100,32'h00208133,2,0,0,1);
    add(0,1,0,0,0,0,0,                      0,0,32'h80000100,32'h00208133,2,0,0,1);
    add(0,0,1,32'h00100073,0,0,0,           0,1,32'h80000100,32'h00100073,2,0,0,1);
    add(0,0,0,0,1,32'h80000104,1,           0,0,32'h80000104,32'h00100073,3,1,0,1);
    add(0,1,1,32'hffffffff,1,0,0,           0,0,32'h80000104,32'h00100073,3,1,0,1);
    add(1,0,0,0,0,0,0,                      1,0,P0,NOP,0,0,0,0);
    add(0,1,0,0,0,0,0,                      0,0,P0,NOP,0,0,0,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0,0,0, 0,0,P0,NOP,0,0,0,0);
    add(0,0,0,0,0,0,0,                      0,0,P0,NOP,0,0,1,0);
    add(0,1,1,32'h00500093,1,32'h4,1,       0,0,P0,NOP,0,0,1,0);
    add(1,0,0,0,0,0,0,                      1,0,P0,NOP,0,0,0,0);
    add(0,1,0,0,0,0,0,                      0,0,P0,NOP,0,0,0,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0,0,0, 0,0,P0,NOP,0,0,0,0);
    add(0,0,1,32'h00500093,0,0,0,           0,1,P0,32'h00500093,0,0,0,0);
    add(1,0,0,0,0,0,0,                      1,0,P0,NOP,0,0,0,0);
    add(0,1,0,0,0,0,0,                      0,0,P0,NOP,0,0,0,0);
    add(1,0,0,0,0,0,0,                      1,0,P0,NOP,0,0,0,0);
    add(0,0,1,32'h12345678,0,0,0,           1,0,P0,NOP,0,0,0,0);
    foreach (vq[k]) begin
      step(vq[k].r, vq[k].rdy, vq[k].rv, vq[k].d, vq[k].cm, vq[k].npc, vq[k].hl);
      chk($sformatf("v%0d req_valid", k), 64'(imem_req_valid), 64'(vq[k].e_req));
      chk($sformatf("v%0d inst_valid", k), 64'(inst_valid), 64'(vq[k].e_iv));
      chk($sformatf("v%0d pc", k), 64'(pc), 64'(vq[k].e_pc));
      chk($sformatf("v%0d req_addr", k), 64'(imem_req_addr), 64'(vq[k].e_pc));
      chk($sformatf("v%0d inst", k), 64'(inst), 64'(vq[k].e_inst));
      chk($sformatf("v%0d opcode", k), 64'(opcode), 64'(vq[k].e_inst[6:0]));
      chk($sformatf("v%0d rd", k), 64'(rd), 64'(vq[k].e_inst[11:7]));
      chk($sformatf("v%0d rs1", k), 64'(rs1), 64'(vq[k].e_inst[19:15]));
      chk($sformatf("v%0d instret", k), instret, vq[k].e_ir);
      chk($sformatf("v%0d halted", k), 64'(halted), 64'(vq[k].e_h));
      chk($sformatf("v%0d fetch_err", k), 64'(fetch_err), 64'(vq[k].e_fe));
      chk($sformatf("v%0d misalign", k), 64'(misalign), 64'(vq[k].e_mis));
    end
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("bp%0d req_valid", i), 64'(imem_req_valid), 64'd1);
      chk($sformatf("bp%0d req_addr", i), 64'(imem_req_addr), 64'(P0));
    end
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("lat%0d req_valid", i), 64'(imem_req_valid), 64'd0);
      chk($sformatf("lat%0d inst_valid", i), 64'(inst_valid), 64'd0);
    end
    step(0, 0, 1, 32'h403100b3, 0, 0, 0);
    chk("lat inst_valid", 64'(inst_valid), 64'd1);
    chk("lat opcode", 64'(opcode), 64'h33);
    chk("lat funct3", 64'(funct3), 64'h0);
    chk("lat funct7", 64'(funct7), 64'h1);
    chk("lat rs1", 64'(rs1), 64'd2);
    chk("lat rs2", 64'(rs2), 64'd3);
    chk("lat rd", 64'(rd), 64'd1);
    step(0, 0, 0, 0, 1, 32'h80000200, 1);
    chk("halt halted", 64'(halted), 64'd1);
    chk("halt instret", instret, 64'd1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 32'hffffffff, i[0], 32'h4, i[1]);
      chk($sformatf("hold%0d req_valid", i), 64'(imem_req_valid), 64'd0);
      chk($sformatf("hold%0d inst_valid", i), 64'(inst_valid), 64'd0);
      chk($sformatf("hold%0d instret", i), instret, 64'd1);
      chk($sformatf("hold%0d pc", i), 64'(pc), 64'h80000200);
      chk($sformatf("hold%0d inst", i), 64'(inst), 64'h403100b3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
